// File: rtl/uart_cmd_frame_parser_pkg.sv
// uart_cmd_frame_parser_pkg: frame byte defaults and parser state encoding
package uart_cmd_frame_parser_pkg;
  localparam logic [7:0] HEADER_DEF   = 8'h5A;
  localparam logic [7:0] DEV_ADDR_DEF = 8'h86;
  localparam logic [7:0] TAIL_DEF     = 8'hEA;
  typedef enum logic [2:0] {S_IDLE, S_ADDR, S_TIME, S_CTRL, S_TAIL} state_t;
endpackage

// File: rtl/uart_cmd_frame_parser.sv
// uart_cmd_frame_parser: assembles 8-byte command frames into LED time/pattern config
module uart_cmd_frame_parser
  import uart_cmd_frame_parser_pkg::*;
#(
  parameter logic [7:0]  HEADER      = HEADER_DEF,
  parameter logic [7:0]  DEV_ADDR    = DEV_ADDR_DEF,
  parameter logic [7:0]  TAIL        = TAIL_DEF,
  parameter int          TIMEOUT_CYC = 500_000,
  parameter logic [31:0] TIME_RST    = 32'd25_000_000
) (
  input  logic        sys_clk,
  input  logic        rst,
  input  logic [7:0]  rx_data,
  input  logic        rx_done,
  output logic [31:0] time_set,
  output logic [7:0]  ctrl_set,
  output logic        cfg_valid,
  output logic        frame_err,
  output logic        busy
);
  localparam int CW = $clog2(TIMEOUT_CYC);
  state_t          r_state, w_next;
  logic [1:0]      r_byte_cnt;
  logic [31:0]     r_shadow_time;
  logic [7:0]      r_shadow_ctrl;
  logic [CW-1:0]   r_to_cnt;
  logic            w_timeout, w_accept, w_bad_tail;
  // a strobe on the terminal-count cycle takes priority over the timeout
  assign w_timeout  = (r_state != S_IDLE) && !rx_done && (r_to_cnt == CW'(TIMEOUT_CYC - 1));
  assign w_accept   = rx_done && (r_state == S_TAIL) && (rx_data == TAIL);
  assign w_bad_tail = rx_done && (r_state == S_TAIL) && (rx_data != TAIL);
  assign busy       = (r_state != S_IDLE);
  always_comb begin
    w_next = r_state;
    if (rx_done) begin
      case (r_state)
        S_IDLE:  w_next = (rx_data == HEADER) ? S_ADDR : S_IDLE;
        S_ADDR:  w_next = (rx_data == DEV_ADDR) ? S_TIME : S_IDLE;
        S_TIME:  w_next = (r_byte_cnt == 2'd3) ? S_CTRL : S_TIME;
        S_CTRL:  w_next = S_TAIL;
        default: w_next = S_IDLE;
      endcase
    end else if (w_timeout) begin
      w_next = S_IDLE;
    end
  end
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_byte_cnt    <= '0;
      r_shadow_time <= '0;
      r_shadow_ctrl <= '0;
      r_to_cnt      <= '0;
      time_set      <= TIME_RST;
      ctrl_set      <= '0;
      cfg_valid     <= 1'b0;
      frame_err     <= 1'b0;
    end else begin
      r_state   <= w_next;
      cfg_valid <= w_accept;
      frame_err <= w_bad_tail || w_timeout;
      r_to_cnt  <= (rx_done || w_timeout || r_state == S_IDLE) ? '0 : r_to_cnt + 1'b1;
      if (rx_done && r_state == S_ADDR) r_byte_cnt <= '0;
      if (rx_done && r_state == S_TIME) begin
        r_shadow_time[{r_byte_cnt, 3'b000} +: 8] <= rx_data;
        r_byte_cnt <= r_byte_cnt + 1'b1;
      end
      if (rx_done && r_state == S_CTRL) r_shadow_ctrl <= rx_data;
      if (w_accept) begin
        time_set <= r_shadow_time;
        ctrl_set <= r_shadow_ctrl;
      end
    end
  end
endmodule

// File: tb/tb_uart_cmd_frame_parser.sv
// tb_uart_cmd_frame_parser: table vectors, corner sequences and random frames vs a frame-level model
module tb_uart_cmd_frame_parser;
  localparam int          TO       = 1000;
  localparam logic [31:0] TIME_RST = 32'd25_000_000;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  rx_data = '0;
  logic        rx_done = 1'b0;
  logic [31:0] time_set;
  logic [7:0]  ctrl_set;
  logic        cfg_valid, frame_err, busy;
  uart_cmd_frame_parser #(.TIMEOUT_CYC(TO), .TIME_RST(TIME_RST)) dut (
    .sys_clk(clk), .rst(rst), .rx_data(rx_data), .rx_done(rx_done),
    .time_set(time_set), .ctrl_set(ctrl_set), .cfg_valid(cfg_valid),
    .frame_err(frame_err), .busy(busy)
  );
  always #5 clk = ~clk;
  int n_cmp = 0, n_err = 0;
  int cv_cnt = 0, fe_cnt = 0;
  logic [7:0]  q[$];
  int          since = 0;
  logic [31:0] m_time = TIME_RST;
  logic [7:0]  m_ctrl = '0;
  logic        m_cv = 1'b0, m_fe = 1'b0;
  typedef struct {
    logic [63:0] frame;
    int          exp_cv;
    int          exp_fe;
    logic [31:0] exp_time;
    logic [7:0]  exp_ctrl;
  } vec_t;
  vec_t vt[4];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask
  // frame-level model: the bytes of the current frame kept in a queue
  task automatic model_byte(input logic [7:0] b);
    since = 0;
    if (q.size() == 0) begin
      if (b == 8'h5A) q.push_back(b);
    end else if (q.size() == 1) begin
      if (b == 8'h86) q.push_back(b);
      else q.delete();
    end else if (q.size() < 7) begin
      q.push_back(b);
    end else begin
      if (b == 8'hEA) begin
        m_time = {q[5], q[4], q[3], q[2]};
        m_ctrl = q[6];
        m_cv = 1'b1;
      end else m_fe = 1'b1;
      q.delete();
    end
  endtask
  task automatic tick();
    m_cv = 1'b0;
    m_fe = 1'b0;
    if (rst) begin
      q.delete();
      since = 0;
      m_time = TIME_RST;
      m_ctrl = '0;
    end else if (rx_done) begin
      model_byte(rx_data);
    end else if (q.size() > 0) begin
      since++;
      if (since == TO) begin
        m_fe = 1'b1;
        q.delete();
        since = 0;
      end
    end
    @(posedge clk);
    #1;
    chk("time_set", time_set, m_time);
    chk("ctrl_set", {24'd0, ctrl_set}, {24'd0, m_ctrl});
    chk("cfg_valid", {31'd0, cfg_valid}, {31'd0, m_cv});
    chk("frame_err", {31'd0, frame_err}, {31'd0, m_fe});
    chk("busy", {31'd0, busy}, {31'd0, (q.size() > 0)});
    if (cfg_valid === 1'b1) cv_cnt++;
    if (frame_err === 1'b1) fe_cnt++;
  endtask
  task automatic send(input logic [7:0] b, input int gap);
    rx_data = b;
    rx_done = 1'b1;
    tick();
    rx_done = 1'b0;
    rx_data = $urandom_range(0, 255);
    repeat (gap) tick();
  endtask
  task automatic send_frame(input logic [63:0] f, input int gap);
    logic [63:0] fr;
    fr = f;
    for (int i = 0; i < 8; i++) send(fr[63-8*i -: 8], gap);
  endtask
  initial begin
    int cv0, fe0, lat;
    logic [63:0] f;
    vt[0] = '{64'h5A86_50C3_0000_ABEA, 1, 0, 32'h0000C350, 8'hAB};
    vt[1] = '{64'h5A86_8813_0000_5A00, 0, 1, 32'h0000C350, 8'hAB};
    vt[2] = '{64'h5A87_50C3_0000_ABEA, 0, 0, 32'h0000C350, 8'hAB};
    vt[3] = '{64'h5A86_8813_0000_5AEA, 1, 0, 32'h00001388, 8'h5A};
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    repeat (3) tick();
    chk("reset_time", time_set, TIME_RST);
    for (int v = 0; v < 4; v++) begin
      cv0 = cv_cnt;
      fe0 = fe_cnt;
      send_frame(vt[v].frame, 10);
      chk($sformatf("vec%0d_cfg_pulses", v), cv_cnt - cv0, vt[v].exp_cv);
      chk($sformatf("vec%0d_err_pulses", v), fe_cnt - fe0, vt[v].exp_fe);
      chk($sformatf("vec%0d_time", v), time_set, vt[v].exp_time);
      chk($sformatf("vec%0d_ctrl", v), {24'd0, ctrl_set}, {24'd0, vt[v].exp_ctrl});
      chk($sformatf("vec%0d_busy", v), {31'd0, busy}, 32'd0);
    end
    // timeout: frame_err exactly TO cycles after the last strobe
    cv0 = cv_cnt;
    send(8'h5A, 10);
    send(8'h86, 10);
    send(8'h50, 0);
    lat = -1;
    for (int i = 1; i <= TO + 50 && lat < 0; i++) begin
      tick();
      if (frame_err === 1'b1) lat = i;
    end
    chk("timeout_latency", lat, TO);
    chk("timeout_busy", {31'd0, busy}, 32'd0);
    send_frame(64'h5A86_1027_0000_33EA, 10);
    chk("after_timeout_time", time_set, 32'h00002710);
    chk("after_timeout_cfg", cv_cnt - cv0, 1);
    // reset mid-frame
    cv0 = cv_cnt;
    fe0 = fe_cnt;
    send(8'h5A, 10); send(8'h86, 10); send(8'h50, 10); send(8'hC3, 10);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    send(8'h00, 10); send(8'h00, 10); send(8'hAB, 10); send(8'hEA, 10);
    chk("rst_mid_cfg", cv_cnt - cv0, 0);
    chk("rst_mid_err", fe_cnt - fe0, 0);
    chk("rst_mid_time", time_set, TIME_RST);
    send_frame(64'h5A86_50C3_0000_ABEA, 10);
    chk("rst_after_time", time_set, 32'h0000C350);
    // strobe landing exactly on the terminal-count cycle
    cv0 = cv_cnt;
    fe0 = fe_cnt;
    send(8'h5A, 10);
    send(8'h86, TO - 1);
    send(8'h11, TO - 1);
    send(8'h22, 10); send(8'h00, 10); send(8'h00, 10); send(8'h77, 10); send(8'hEA, 10);
    chk("term_err", fe_cnt - fe0, 0);
    chk("term_cfg", cv_cnt - cv0, 1);
    chk("term_time", time_set, 32'h00002211);
    chk("term_ctrl", {24'd0, ctrl_set}, 32'h77);
    // random frames with occasional corruption and near-timeout gaps
    for (int n = 0; n < 200; n++) begin
      f = {8'h5A, 8'h86, 32'($urandom), 8'($urandom), 8'hEA};
      if ($urandom_range(0, 3) == 0) f[63 - 8*$urandom_range(0, 7) -: 8] = 8'($urandom);
      for (int i = 0; i < 8; i++)
        send(f[63-8*i -: 8], ($urandom_range(0, 30) == 0) ? $urandom_range(TO - 2, TO + 1) : $urandom_range(0, 12));
      if ($urandom_range(0, 9) == 0) send(8'($urandom), $urandom_range(0, 5));
    end
    repeat (TO + 5) tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
